// File: rtl/cla_seq_divider_if.sv
// Start/done request bus between a control sequencer (master) and the sequential divider (slave).
// Operands travel with start; results are held with done until the next completed operation.
interface cla_seq_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/cla_seq_divider.sv
// Restoring divider, one 4-bit-group carry-lookahead trial subtraction per cycle; done WIDTH+1 cycles after start (1 for divide-by-zero).
// start is ignored while busy; define CLA_DIV_SIGNED_EN for two's-complement operands.
module cla_seq_divider #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  cla_seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef CLA_DIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] prem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             no_borrow;
  logic             accept;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] p, g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Trial subtract = shifted + ~divisor + 1; the extra top bit only has an implicit 1 in B.
  always_comb begin
    logic             carry;
    logic [4:0]       grp;
    logic [WIDTH-1:0] nb;
    shifted = {prem_q, dvd_q[WIDTH-1]};
    nb      = ~dvs_q;
    carry   = 1'b1;
    trial   = '0;
    for (int i = 0; i < NG; i++) begin
      grp              = cla4(shifted[4*i +: 4], nb[4*i +: 4], carry);
      trial[4*i +: 4]  = grp[3:0];
      carry            = grp[4];
    end
    no_borrow = shifted[WIDTH] | carry;
    prem_nx   = no_borrow ? trial : shifted[WIDTH-1:0];
    quo_nx    = {dvd_q[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef CLA_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    accept  = bus.start && (state_q != RUN);

    case (state_q)
      RUN: begin
        prem_d = prem_nx;
        dvd_d  = quo_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
`ifdef CLA_DIV_SIGNED_EN
          quot_d  = qneg_q ? -quo_nx : quo_nx;
          rem_d   = rneg_q ? -prem_nx : prem_nx;
`else
          quot_d  = quo_nx;
          rem_d   = prem_nx;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (accept) begin
`ifdef CLA_DIV_SIGNED_EN
      dvd_d  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
      dvs_d  = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
      qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      rneg_d = bus.dividend[WIDTH-1];
`else
      dvd_d  = bus.dividend;
      dvs_d  = bus.divisor;
`endif
      if (bus.divisor == '0) begin
        state_d = DONE;
        quot_d  = '1;
        rem_d   = bus.dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
        prem_d  = '0;
        cnt_d   = CW'(WIDTH - 1);
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef CLA_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef CLA_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_cla_seq_divider.sv
// Bench for cla_seq_divider: directed scenarios plus random operands against an arithmetic reference model.
// Honours CLA_DIV_SIGNED_EN in the same way as the design.
module tb_cla_seq_divider;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  cla_seq_divider_if #(.WIDTH(W)) bus();
  cla_seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef CLA_DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q = '1; r = a;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q = a; r = '0;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    if (b == '0) begin
      q = '1; r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    issue_now(a, b);
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    for (int k = 1; k <= 4*W; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL reset_quot: got %h want 00", bus.quotient); end
    checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL reset_rem: got %h want 00", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [W-1:0] eq, er;
    model(8'd100, 8'd7, eq, er);
    issue(8'd100, 8'd7);
    wait_done(lat, bc);
    checks++; if (lat !== W+1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W+1); end
    checks++; if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
    checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL basic_quot: got %h want %h", bus.quotient, eq); end
    checks++; if (bus.remainder !== er) begin errors++; $display("FAIL basic_rem: got %h want %h", bus.remainder, er); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL basic_hold: got %h want %h", bus.quotient, eq); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [W-1:0] eq, er, eq2, er2;
    model(8'd255, 8'd1, eq, er);
    model(8'd3, 8'd200, eq2, er2);
    issue(8'd255, 8'd1);
    wait_done(lat, bc);
    checks++; if (bus.quotient !== eq || bus.remainder !== er) begin
      errors++; $display("FAIL b2b_first: got %h r %h want %h r %h", bus.quotient, bus.remainder, eq, er); end
    issue_now(8'd3, 8'd200);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b want 1", bus.busy); end
    checks++; if (bus.quotient !== eq) begin errors++; $display("FAIL b2b_hold: got %h want %h", bus.quotient, eq); end
    wait_done(lat, bc);
    checks++; if (lat !== W) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, W); end
    checks++; if (bus.quotient !== eq2 || bus.remainder !== er2) begin
      errors++; $display("FAIL b2b_second: got %h r %h want %h r %h", bus.quotient, bus.remainder, eq2, er2); end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    issue(8'd5, 8'd0);
    wait_done(lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy: got %0d busy cycles want 0", bc); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
    checks++; if (bus.quotient !== 8'hFF) begin errors++; $display("FAIL dbz_quot: got %h want ff", bus.quotient); end
    checks++; if (bus.remainder !== 8'd5) begin errors++; $display("FAIL dbz_rem: got %h want 05", bus.remainder); end
  endtask

  task automatic test_busy_ignore;
    int lat, bc;
    logic [W-1:0] eq, er;
    model(8'd100, 8'd7, eq, er);
    issue(8'd100, 8'd7);
    lat = 0; bc = 0;
    for (int k = 1; k <= 4*W; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      bus.start = (k == 4);
      if (k == 4) begin bus.dividend = 8'd9; bus.divisor = 8'd3; end
      if (bus.done) begin lat = k; break; end
    end
    bus.start = 1'b0;
    checks++; if (lat !== W+1) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, W+1); end
    checks++; if (bus.quotient !== eq || bus.remainder !== er) begin
      errors++; $display("FAIL ignore_result: got %h r %h want %h r %h", bus.quotient, bus.remainder, eq, er); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ignore_dbz_clear: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_reset_abort;
    int lat, bc;
    bit seen;
    logic [W-1:0] eq, er;
    issue(8'd200, 8'd9);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL abort_flags: busy %b done %b dbz %b want 0 0 0", bus.busy, bus.done, bus.div_by_zero); end
    checks++; if (bus.quotient !== '0 || bus.remainder !== '0) begin
      errors++; $display("FAIL abort_data: got %h r %h want 00 r 00", bus.quotient, bus.remainder); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2*W; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: activity %b want 0", seen); end
    model(8'd200, 8'd9, eq, er);
    issue(8'd200, 8'd9);
    wait_done(lat, bc);
    checks++; if (lat !== W+1 || bus.quotient !== eq || bus.remainder !== er) begin
      errors++; $display("FAIL abort_rerun: lat %0d got %h r %h want %0d %h r %h", lat, bus.quotient, bus.remainder, W+1, eq, er); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [W-1:0] a, b, eq, er;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(a, b, eq, er);
      if (n > 0 && $urandom_range(0, 1) == 1) issue_now(a, b);
      else issue(a, b);
      wait_done(lat, bc);
      checks++; if (lat !== ((b == '0) ? 1 : W+1)) begin
        errors++; $display("FAIL rand_latency %h/%h: got %0d", a, b, lat); end
      checks++; if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== (b == '0)) begin
        errors++; $display("FAIL rand_result %h/%h: got %h r %h z %b want %h r %h z %b",
                           a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, (b == '0)); end
    end
  endtask

`ifdef CLA_DIV_SIGNED_EN
  task automatic test_signed;
    int lat, bc;
    issue(8'h9C, 8'd7);
    wait_done(lat, bc);
    checks++; if (bus.quotient !== 8'hF2 || bus.remainder !== 8'hFE) begin
      errors++; $display("FAIL signed_neg100_7: got %h r %h want f2 r fe", bus.quotient, bus.remainder); end
    issue(8'h80, 8'hFF);
    wait_done(lat, bc);
    checks++; if (lat !== W+1 || bus.quotient !== 8'h80 || bus.remainder !== 8'h00) begin
      errors++; $display("FAIL signed_minneg: lat %0d got %h r %h want %0d 80 r 00", lat, bus.quotient, bus.remainder, W+1); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_busy_ignore;
    test_reset_abort;
`ifdef CLA_DIV_SIGNED_EN
    test_signed;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
